// File: rtl/heart_beat_ctrl_pkg.sv
// Shared VGA constants and beat FSM state encoding for the heart display path.
// Contents:
//   SCR_W/SCR_H  - visible screen size in pixels
//   ROM_W/ROM_H  - heart artwork size in ROM texels
//   beat_state_t - beat sequencer states
//   centre_pos   - top/left offset that centres scaled art on one axis
package heart_beat_ctrl_pkg;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int ROM_W = 100;
    localparam int ROM_H = 92;

    typedef enum logic [1:0] {
        LUB  = 2'd0,
        GAP  = 2'd1,
        DUB  = 2'd2,
        REST = 2'd3
    } beat_state_t;

    // (scr - rom*eff)/2 in 11-bit unsigned; the legal size range keeps the
    // subtraction non-negative, so the shifted result always fits 10 bits.
    function automatic logic [9:0] centre_pos(input int scr, input int rom,
                                              input logic [3:0] eff);
        logic [10:0] span;
        logic [10:0] diff;
        span = 11'(rom) * {7'd0, eff};
        diff = 11'(scr) - span;
        return diff[10:1];
    endfunction

endpackage

// File: rtl/heart_beat_ctrl_btn_repeat.sv
// Button conditioner: 2-FF synchroniser, tick-rate debounce and auto-repeat.
// Ports:
//   clk, rst  - clock, async active-high reset
//   btn_raw   - asynchronous raw button
//   tick      - one-cycle prescaler strobe; all debounce timing is in ticks
//   step      - one-cycle pulse (coincident with tick) per accepted step
module btn_repeat #(
    parameter int DB_TICKS     = 3,
    parameter int REPEAT_TICKS = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic tick,
    output logic step
);

    localparam int DBW = $clog2(DB_TICKS + 1);
    localparam int RPW = $clog2(REPEAT_TICKS + 1);
    localparam logic [DBW-1:0] DB_FULL = DBW'(DB_TICKS);
    localparam logic [RPW-1:0] RP_LOAD = RPW'(REPEAT_TICKS);
    localparam logic [RPW-1:0] RP_ONE  = RPW'(1);

    logic [1:0]     sync_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [RPW-1:0] rpt_q, rpt_d;
    logic           step_d;

    always_comb begin
        db_cnt_d = db_cnt_q;
        rpt_d    = rpt_q;
        step_d   = 1'b0;
        if (tick) begin
            if (!sync_q[1]) begin
                // any low sample restarts both debounce and repeat timing
                db_cnt_d = '0;
                rpt_d    = '0;
            end else if (db_cnt_q != DB_FULL) begin
                db_cnt_d = db_cnt_q + 1'b1;
                if (db_cnt_d == DB_FULL) begin
                    step_d = 1'b1;
                    rpt_d  = RP_LOAD;
                end
            end else if (rpt_q == RP_ONE) begin
                step_d = 1'b1;
                rpt_d  = RP_LOAD;
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end
    end

    assign step = step_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b00;
            db_cnt_q <= '0;
            rpt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw};
            db_cnt_q <= db_cnt_d;
            rpt_q    <= rpt_d;
        end
    end

endmodule

// File: rtl/heart_beat_ctrl.sv
// Heart display controller: lub-dub beat sequencer, size buttons, centring.
// Ports:
//   clk, rst           - pixel clock, async active-high reset
//   inc_size, dec_size - raw size buttons (asynchronous)
//   mode               - 0: on/off blink, 1: big/small pulse
//   beat               - beat pattern
//   size               - base pixel size
//   wpixel, hpixel     - effective pixel width/height
//   x_scr, y_scr       - heart left column / top row
//   show               - heart visible
//
// state | meaning
// LUB   | first pulse, beat high for LUB_T ticks
// GAP   | beat low for GAP_T ticks
// DUB   | second pulse, beat high for DUB_T ticks
// REST  | beat low for REST_T ticks (reset state)
module heart_beat_ctrl
    import heart_beat_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 250000,
    parameter int LUB_T        = 12,
    parameter int GAP_T        = 10,
    parameter int DUB_T        = 10,
    parameter int REST_T       = 48,
    parameter int DB_TICKS     = 3,
    parameter int REPEAT_TICKS = 25,
    parameter int MIN_SIZE     = 1,
    parameter int MAX_SIZE     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_size,
    input  logic       dec_size,
    input  logic       mode,
    output logic       beat,
    output logic [3:0] size,
    output logic [3:0] wpixel,
    output logic [3:0] hpixel,
    output logic [9:0] x_scr,
    output logic [9:0] y_scr,
    output logic       show
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam int T_AB  = (LUB_T > GAP_T) ? LUB_T : GAP_T;
    localparam int T_CD  = (DUB_T > REST_T) ? DUB_T : REST_T;
    localparam int T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
    localparam int DW    = $clog2(T_MAX + 1);

    localparam logic [3:0] SIZE_RST = 4'd3;
    localparam logic [3:0] MIN_SZ   = 4'(MIN_SIZE);
    localparam logic [3:0] MAX_SZ   = 4'(MAX_SIZE);
    localparam logic [9:0] X_RST    = centre_pos(SCR_W, ROM_W, SIZE_RST);
    localparam logic [9:0] Y_RST    = centre_pos(SCR_H, ROM_H, SIZE_RST);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    beat_state_t   state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          beat_q, beat_d;
    logic [3:0]    size_q, size_d;
    logic [3:0]    eff_q, eff_d;
    logic          show_q, show_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          inc_step, dec_step;

    btn_repeat #(.DB_TICKS(DB_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_inc (
        .clk(clk), .rst(rst), .btn_raw(inc_size), .tick(tick), .step(inc_step)
    );

    btn_repeat #(.DB_TICKS(DB_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_dec (
        .clk(clk), .rst(rst), .btn_raw(dec_size), .tick(tick), .step(dec_step)
    );

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        beat_d  = beat_q;
        if (tick) begin
            if (dwell_q == DW'(1)) begin
                case (state_q)
                    LUB:     begin state_d = GAP;  dwell_d = DW'(GAP_T);  beat_d = 1'b0; end
                    GAP:     begin state_d = DUB;  dwell_d = DW'(DUB_T);  beat_d = 1'b1; end
                    DUB:     begin state_d = REST; dwell_d = DW'(REST_T); beat_d = 1'b0; end
                    default: begin state_d = LUB;  dwell_d = DW'(LUB_T);  beat_d = 1'b1; end
                endcase
            end else begin
                dwell_d = dwell_q - 1'b1;
            end
        end
    end

    // Simultaneous inc and dec steps cancel; in pulse mode steps are dropped.
    always_comb begin
        size_d = size_q;
        if (!mode && (inc_step != dec_step)) begin
            if (inc_step) begin
                if (size_q < MAX_SZ) size_d = size_q + 4'd1;
            end else if (size_q > MIN_SZ) begin
                size_d = size_q - 4'd1;
            end
        end
    end

    always_comb begin
        eff_d  = size_q + {3'b000, beat_q & mode};
        show_d = mode | beat_q;
        x_d    = centre_pos(SCR_W, ROM_W, eff_q);
        y_d    = centre_pos(SCR_H, ROM_H, eff_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            state_q <= REST;
            dwell_q <= DW'(REST_T);
            beat_q  <= 1'b0;
            size_q  <= SIZE_RST;
            eff_q   <= SIZE_RST;
            show_q  <= 1'b0;
            x_q     <= X_RST;
            y_q     <= Y_RST;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            dwell_q <= dwell_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            eff_q   <= eff_d;
            show_q  <= show_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign beat   = beat_q;
    assign size   = size_q;
    assign wpixel = eff_q;
    assign hpixel = eff_q;
    assign x_scr  = x_q;
    assign y_scr  = y_q;
    assign show   = show_q;

endmodule

// File: doc/heart_beat_ctrl.md
# heart_beat_ctrl

Controller that sequences the heart display on the VGA path. Generates the two-phase "lub-dub" beat pattern from a tick prescaler and debounces the size buttons with auto-repeat. Holds the pixel-size register clamped to a legal range and emits centred heart coordinates, pixel dimensions and the show enable consumed by the heart graphics/ROM stage.

## Interface
Parameters:
- `TICK_DIV`, 250000, clk cycles per tick (10 ms at 25 MHz pixel clock)
- `LUB_T`, 12, ticks beat high, first pulse
- `GAP_T`, 10, ticks beat low between pulses
- `DUB_T`, 10, ticks beat high, second pulse
- `REST_T`, 48, ticks beat low after second pulse
- `DB_TICKS`, 3, consecutive high ticks to accept a press
- `REPEAT_TICKS`, 25, ticks between auto-repeat steps while held
- `MIN_SIZE`, 1, smallest size
- `MAX_SIZE`, 4, largest size; MAX_SIZE+1 must fit 100x92 art in 640x480

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system/pixel clock
- `rst` in 1: async active-high reset
- `inc_size` in 1: raw button, asynchronous
- `dec_size` in 1: raw button, asynchronous
- `mode` in 1: 0 = on/off blink, 1 = big/small pulse
- `beat` out 1: beat pattern
- `size` out 4: base pixel size
- `wpixel` out 4: effective pixel width
- `hpixel` out 4: effective pixel height
- `x_scr` out 10: heart left column
- `y_scr` out 10: heart top row
- `show` out 1: heart visible

## Operation
- Prescaler: counter 0..TICK_DIV-1; `tick` is a one-cycle internal strobe at wrap.
- Beat FSM, advances only on tick, dwell counter reloaded on each transition:
  - LUB (beat=1, LUB_T) → GAP (beat=0, GAP_T) → DUB (beat=1, DUB_T) → REST (beat=0, REST_T) → LUB.
- Buttons: 2-FF synchroniser each, sampled on tick.
  - A press is accepted after DB_TICKS consecutive high samples; any low sample clears the count and the repeat timer.
  - Accepted press: one step immediately, then one step every REPEAT_TICKS while still high.
- Size update, only when mode=0:
  - inc step: size+1, saturating at MAX_SIZE.
  - dec step: size-1, saturating at MIN_SIZE.
  - inc and dec steps on the same tick: no change.
  - mode=1: steps are discarded; debounce state keeps running.
- eff = size + (beat & mode). wpixel = hpixel = eff (registered).
- x_scr = (640 − 100·eff)/2; y_scr = (480 − 92·eff)/2.
  - Compute in ≥11-bit unsigned; result always non-negative given MAX_SIZE.
- show = mode ? 1 : beat.

## Timing
- Reset values:
  - prescaler 0, FSM in REST with dwell REST_T, beat 0, show 0
  - size 3, wpixel/hpixel 3, x_scr 170, y_scr 102
- First tick occurs TICK_DIV cycles after reset release.
- beat changes in the cycle after the tick that ends a dwell. show and wpixel/hpixel follow one clk after beat/size; x_scr/y_scr follow one clk after wpixel (2-clk total).
- Button latency: ≥2 clk sync + DB_TICKS ticks to the first step; size updates the cycle after that tick.
- Reset mid-operation clears all state asynchronously, including debounce and repeat counters; held buttons must re-debounce after release of rst.
- A mode change mid-beat takes effect on eff/show one clk later; FSM is unaffected.

## Structure
- Shared VGA package: SCR_W=640, SCR_H=480, ROM_W=100, ROM_H=92; FSM state enum {LUB, GAP, DUB, REST}.
- One sub-module: `btn_repeat` (sync + debounce + auto-repeat, outputs a one-tick `step` pulse), instantiated twice.

## Test plan
Simulate with TICK_DIV=4, LUB_T=2, GAP_T=1, DUB_T=1, REST_T=3, DB_TICKS=2, REPEAT_TICKS=3.
- Reset then free-run → beat low 3 ticks, high 2, low 1, high 1, low 3, repeating; period 7 ticks = 28 clk.
- mode=0, hold inc_size 20 ticks → size 3→4 after 2 ticks, then stays 4 (saturates); x_scr=120, y_scr=56.
- mode=0, hold dec_size → size 3,2,1 at repeat intervals, then holds 1; x_scr=270, y_scr=194.
- mode=1, size 4 → during beat high, wpixel=5, x_scr=70, y_scr=10, show=1 throughout; inc_size press leaves size=4.
- Glitchy inc_size (1-tick pulses) → size unchanged; both buttons held → size unchanged.
- Assert rst mid-DUB while holding inc → all outputs return to reset values immediately.
